// File: rtl/sap1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap1_controller_sequencer
//
// Purpose:
//   Control unit of the SAP-1 datapath. A one-hot ring counter steps through
//   T1..T6 for every instruction. The current T-state, the instruction-register
//   opcode and the halted flag are decoded into the control word. That control
//   word drives the load/enable strobes of PC, MAR, RAM, IR, A, ALU, B and OUT.
//   The control word is Moore-style: it depends only on registered state plus
//   the opcode, so each targeted register loads at the posedge that ends the
//   T-state.
//
// Ports:
//   clk      in   1  system clock; all state changes on posedge
//   clr      in   1  synchronous, active-high reset
//   opcode   in   4  IR[7:4]; decoded from T4 onward
//   Cp       out  1  PC increment
//   Ep       out  1  PC drives bus
//   Lm       out  1  MAR loads from bus
//   Ce       out  1  RAM drives bus
//   Li       out  1  IR loads from bus
//   Ei       out  1  IR address nibble drives bus
//   La       out  1  accumulator loads from bus
//   Ea       out  1  accumulator drives bus
//   Su       out  1  ALU subtract (0 = add)
//   Eu       out  1  ALU drives bus
//   Lb       out  1  B register loads from bus
//   Lo       out  1  output register loads from bus
//   halted   out  1  HLT executed; sequencer frozen until clr
//   t_state  out  6  one-hot ring counter; bit0 = T1 ... bit5 = T6
// -----------------------------------------------------------------------------
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA    = 4'b0000,
  parameter logic [3:0] OP_ADD    = 4'b0001,
  parameter logic [3:0] OP_SUB    = 4'b0010,
  parameter logic [3:0] OP_OUT    = 4'b1110,
  parameter logic [3:0] OP_HLT    = 4'b1111,
  parameter bit         EARLY_END = 1'b0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm,
  output logic       Ce,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo,
  output logic       halted,
  output logic [5:0] t_state
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e t_state_q, t_state_d;
  logic     halted_q,  halted_d;

  logic is_lda, is_add_sub, is_hlt;

  assign is_lda     = (opcode == OP_LDA);
  assign is_add_sub = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_hlt     = (opcode == OP_HLT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (clr) begin
      t_state_q <= T1;
      halted_q  <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      halted_q  <= halted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statements leaves it unassigned and no latch is inferred.
  always_comb begin
    t_state_d = t_state_q;
    halted_d  = halted_q;
    if (!halted_q) begin
      case (t_state_q)
        T1: t_state_d = T2;
        T2: t_state_d = T3;
        T3: t_state_d = T4;
        T4: begin
          if (is_hlt) begin
            // Freeze at T4; the ring stops advancing from the next cycle on.
            halted_d = 1'b1;
          end else if (EARLY_END && !is_lda && !is_add_sub) begin
            // OUT and every NOP opcode have no work after T4.
            t_state_d = T1;
          end else begin
            t_state_d = T5;
          end
        end
        T5: t_state_d = (EARLY_END && is_lda) ? T1 : T6;
        T6: t_state_d = T1;
        // A corrupted (non one-hot) ring restarts the instruction cleanly.
        default: t_state_d = T1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control word decode
  // ---------------------------------------------------------------------------
  always_comb begin
    Cp = 1'b0; Ep = 1'b0; Lm = 1'b0; Ce = 1'b0;
    Li = 1'b0; Ei = 1'b0; La = 1'b0; Ea = 1'b0;
    Su = 1'b0; Eu = 1'b0; Lb = 1'b0; Lo = 1'b0;
    if (!halted_q) begin
      case (t_state_q)
        T1: begin Ep = 1'b1; Lm = 1'b1; end
        T2: begin Cp = 1'b1; end
        T3: begin Ce = 1'b1; Li = 1'b1; end
        T4: begin
          if (is_lda || is_add_sub) begin
            Ei = 1'b1; Lm = 1'b1;
          end else if (opcode == OP_OUT) begin
            Ea = 1'b1; Lo = 1'b1;
          end
        end
        T5: begin
          if (is_lda) begin
            Ce = 1'b1; La = 1'b1;
          end else if (is_add_sub) begin
            Ce = 1'b1; Lb = 1'b1;
          end
        end
        T6: begin
          if (is_add_sub) begin
            Eu = 1'b1; La = 1'b1;
            Su = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign halted  = halted_q;
  assign t_state = t_state_q;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap1_controller_sequencer
//
// Drives two instances (EARLY_END=0 and EARLY_END=1) from the same clk, clr and
// opcode. A behavioural model tracks, for each instance, the T-step number and
// the halted flag. The model derives the expected control word from the
// per-opcode strobe table. Directed sequences pin the model with literal
// expectations, and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_sap1_controller_sequencer;

  // Control word bit positions: {Cp,Ep,Lm,Ce,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
  localparam logic [11:0] B_CP = 12'h800, B_EP = 12'h400, B_LM = 12'h200,
                          B_CE = 12'h100, B_LI = 12'h080, B_EI = 12'h040,
                          B_LA = 12'h020, B_EA = 12'h010, B_SU = 12'h008,
                          B_EU = 12'h004, B_LB = 12'h002, B_LO = 12'h001;
  localparam logic [11:0] BUS_EN = B_EP | B_CE | B_EI | B_EA | B_EU;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] opcode = 4'h0;

  logic Cp0, Ep0, Lm0, Ce0, Li0, Ei0, La0, Ea0, Su0, Eu0, Lb0, Lo0, halted0;
  logic Cp1, Ep1, Lm1, Ce1, Li1, Ei1, La1, Ea1, Su1, Eu1, Lb1, Lo1, halted1;
  logic [5:0] t0, t1;
  logic [11:0] ctrl0, ctrl1;

  assign ctrl0 = {Cp0, Ep0, Lm0, Ce0, Li0, Ei0, La0, Ea0, Su0, Eu0, Lb0, Lo0};
  assign ctrl1 = {Cp1, Ep1, Lm1, Ce1, Li1, Ei1, La1, Ea1, Su1, Eu1, Lb1, Lo1};

  sap1_controller_sequencer #(.EARLY_END(1'b0)) dut0 (
    .clk(clk), .clr(clr), .opcode(opcode),
    .Cp(Cp0), .Ep(Ep0), .Lm(Lm0), .Ce(Ce0), .Li(Li0), .Ei(Ei0),
    .La(La0), .Ea(Ea0), .Su(Su0), .Eu(Eu0), .Lb(Lb0), .Lo(Lo0),
    .halted(halted0), .t_state(t0)
  );

  sap1_controller_sequencer #(.EARLY_END(1'b1)) dut1 (
    .clk(clk), .clr(clr), .opcode(opcode),
    .Cp(Cp1), .Ep(Ep1), .Lm(Lm1), .Ce(Ce1), .Li(Li1), .Ei(Ei1),
    .La(La1), .Ea(Ea1), .Su(Su1), .Eu(Eu1), .Lb(Lb1), .Lo(Lo1),
    .halted(halted1), .t_state(t1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: step number 1..6 and a halted flag per instance
  // ---------------------------------------------------------------------------
  function automatic int inst_len(input logic [3:0] op, input bit early);
    if (!early) return 6;
    case (op)
      4'b0000:          return 5;
      4'b0001, 4'b0010: return 6;
      default:          return 4;  // OUT and NOP (HLT never reaches its end)
    endcase
  endfunction

  function automatic logic [11:0] exp_ctrl(input int step, input logic [3:0] op,
                                           input bit hlt);
    if (hlt) return 12'h000;
    case (step)
      1: return B_EP | B_LM;
      2: return B_CP;
      3: return B_CE | B_LI;
      default: ;
    endcase
    case (op)
      4'b0000: return (step == 4) ? (B_EI | B_LM) : (step == 5) ? (B_CE | B_LA) : 12'h000;
      4'b0001: return (step == 4) ? (B_EI | B_LM) : (step == 5) ? (B_CE | B_LB)
                                                  : (B_EU | B_LA);
      4'b0010: return (step == 4) ? (B_EI | B_LM) : (step == 5) ? (B_CE | B_LB)
                                                  : (B_SU | B_EU | B_LA);
      4'b1110: return (step == 4) ? (B_EA | B_LO) : 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  int step_m[2];
  bit hlt_m[2];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 2; k++) begin
        step_m[k] <= 1;
        hlt_m[k]  <= 1'b0;
      end
      m_valid <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!hlt_m[k]) begin
          if (opcode == 4'hF && step_m[k] == 4)
            hlt_m[k] <= 1'b1;
          else if (step_m[k] == 6 || step_m[k] == inst_len(opcode, k == 1))
            step_m[k] <= 1;
          else
            step_m[k] <= step_m[k] + 1;
        end
      end
    end
  end

  // Single compare process, on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("t_state0", {26'd0, t0}, 32'(6'b1 << (step_m[0] - 1)));
      check("halted0",  {31'd0, halted0}, {31'd0, hlt_m[0]});
      check("ctrl0",    {20'd0, ctrl0}, {20'd0, exp_ctrl(step_m[0], opcode, hlt_m[0])});
      check("t_state1", {26'd0, t1}, 32'(6'b1 << (step_m[1] - 1)));
      check("halted1",  {31'd0, halted1}, {31'd0, hlt_m[1]});
      check("ctrl1",    {20'd0, ctrl1}, {20'd0, exp_ctrl(step_m[1], opcode, hlt_m[1])});
      check("onehot0",  {31'd0, $onehot(t0)}, 32'd1);
      check("onehot1",  {31'd0, $onehot(t1)}, 32'd1);
      check("bus_rule0", {31'd0, $countones(ctrl0 & BUS_EN) <= 1}, 32'd1);
      check("bus_rule1", {31'd0, $countones(ctrl1 & BUS_EN) <= 1}, 32'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] op);
    clr = 1'b1;
    opcode = op;
    tick();
    clr = 1'b0;
  endtask

  // Counts clocks from T1 until the EARLY_END instance is back at T1.
  task automatic measure(input logic [3:0] op, input int exp_len, input string name);
    int n;
    start(op);
    n = 0;
    do begin
      tick();
      n++;
    end while (t1 !== 6'b000001 && n < 12);
    check(name, n, exp_len);
  endtask

  logic [11:0] lda_seq[6];
  logic [11:0] op_pool[5];

  initial begin
    lda_seq = '{B_EP | B_LM, B_CP, B_CE | B_LI, B_EI | B_LM, B_CE | B_LA, 12'h000};

    // 1: LDA, exact strobes each T-state, back to T1 after 6 clocks
    start(4'b0000);
    check("reset_t_state", {26'd0, t0}, 32'h01);
    check("reset_halted", {31'd0, halted0}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("lda_T%0d", i + 1), {20'd0, ctrl0}, {20'd0, lda_seq[i]});
      tick();
    end
    check("lda_wrap", {26'd0, t0}, 32'h01);

    // 2: ADD / SUB execute strobes
    start(4'b0001);
    repeat (4) tick();
    check("add_T5", {20'd0, ctrl0}, {20'd0, B_CE | B_LB});
    tick();
    check("add_T6", {20'd0, ctrl0}, {20'd0, B_EU | B_LA});
    start(4'b0010);
    repeat (5) tick();
    check("sub_T6", {20'd0, ctrl0}, {20'd0, B_SU | B_EU | B_LA});

    // 3: OUT
    start(4'b1110);
    repeat (3) tick();
    check("out_T4", {20'd0, ctrl0}, {20'd0, B_EA | B_LO});

    // 4: HLT freezes at T4 for good until clr
    start(4'b1111);
    repeat (4) tick();
    for (int i = 0; i < 20; i++) begin
      check("hlt_t_state", {26'd0, t0}, 32'h08);
      check("hlt_ctrl", {20'd0, ctrl0}, 32'd0);
      check("hlt_flag", {31'd0, halted0}, 32'd1);
      tick();
    end
    start(4'b0000);
    check("hlt_exit_t", {26'd0, t0}, 32'h01);
    check("hlt_exit_flag", {31'd0, halted0}, 32'd0);

    // 5: reset in the middle of ADD T5
    start(4'b0001);
    repeat (4) tick();
    check("mid_add_T5", {26'd0, t0}, 32'h10);
    start(4'b0001);
    check("mid_reset_t", {26'd0, t0}, 32'h01);
    check("mid_reset_ctrl", {20'd0, ctrl0}, {20'd0, B_EP | B_LM});

    // 6: EARLY_END instruction lengths
    measure(4'b0000, 5, "early_lda_len");
    measure(4'b1110, 4, "early_out_len");
    measure(4'b0101, 4, "early_nop_len");
    measure(4'b0001, 6, "early_add_len");

    // Randomized phase: opcode changes at random points, occasional clr.
    op_pool = '{12'h000, 12'h001, 12'h002, 12'h00E, 12'h00F};
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          opcode = op_pool[$urandom_range(0, 4)][3:0];
        else
          opcode = 4'($urandom_range(0, 15));
      end
      tick();
    end

    clr = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
